// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   - FSM state encoding (IDLE/REQ/OUT)
//   - next-PC select codes used between the FSM and fetch_next_pc
//   - PC / instruction widths and a word-alignment helper
package fetch_pkg;

   localparam int PC_WIDTH    = 32;
   localparam int INSTR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      NPC_SEQ      = 2'd0,
      NPC_REDIRECT = 2'd1,
      NPC_PEND     = 2'd2
   } npc_sel_t;

   // Instruction words are 4-byte aligned; the two low address bits are dropped.
   function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
      return {addr[PC_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and decode.
//   memory side : mem_req/mem_addr out, mem_ack/mem_rdata back
//   decode side : inst_valid/inst_data/inst_pc out, inst_ready back
// master = fetch sequencer, slave = memory + decode environment.
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic                   mem_req;
   logic [PC_WIDTH-1:0]    mem_addr;
   logic                   mem_ack;
   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic                   inst_valid;
   logic [INSTR_WIDTH-1:0] inst_data;
   logic [PC_WIDTH-1:0]    inst_pc;
   logic                   inst_ready;

   modport master (
      output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
      input  mem_ack, mem_rdata, inst_ready
   );

   modport slave (
      input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
      output mem_ack, mem_rdata, inst_ready
   );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch sequencer.
//   sel         : NPC_SEQ (pc + PC_STEP), NPC_REDIRECT, NPC_PEND
//   pc          : current program counter
//   redirect_pc : live redirect target from execute
//   pend_pc     : redirect target captured while a request was in flight
//   next_pc     : selected value; redirect targets are word-aligned
module fetch_next_pc
   import fetch_pkg::*;
#(
   parameter int PC_STEP = 4
) (
   input  npc_sel_t            sel,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic [PC_WIDTH-1:0] pend_pc,
   output logic [PC_WIDTH-1:0] next_pc
);

   always_comb begin
      next_pc = pc + PC_WIDTH'(PC_STEP);
      case (sel)
         NPC_REDIRECT: next_pc = align_word(redirect_pc);
         NPC_PEND:     next_pc = align_word(pend_pc);
         default:      next_pc = pc + PC_WIDTH'(PC_STEP);
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, requests words from instruction
// memory over req/ack and hands each word plus its PC to decode over
// valid/ready. Redirects from execute squash any wrong-path word.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : fetch permitted; low lets the current fetch finish, then idles
//   redirect_valid  : one-cycle pulse changing the fetch stream
//   redirect_pc     : redirect target (low two bits ignored)
//   bus             : memory + decode handshakes (fetch_sequencer_if.master)
//   busy            : FSM not idle
//   fetch_count     : instructions accepted by decode (wraps)
//
// state | meaning
// IDLE  | no request outstanding; redirects just reload pc
// REQ   | mem_req high at mem_addr=pc, waiting for mem_ack
// OUT   | instruction presented to decode, waiting for inst_ready
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
   parameter int                  PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   fetch_sequencer_if.master   bus,
   output logic                busy,
   output logic [31:0]         fetch_count
);

   fetch_state_t           state;
   logic [PC_WIDTH-1:0]    pc;
   logic [PC_WIDTH-1:0]    pend_pc;
   logic                   squash;
   logic [INSTR_WIDTH-1:0] inst_data_q;
   logic [PC_WIDTH-1:0]    inst_pc_q;
   npc_sel_t               npc_sel;
   logic [PC_WIDTH-1:0]    next_pc;

   // Outside REQ the only pc update is a redirect. Inside REQ a live redirect
   // beats a pending one, and a clean ack advances sequentially.
   always_comb begin
      npc_sel = NPC_REDIRECT;
      if (state == REQ && !redirect_valid) begin
         npc_sel = squash ? NPC_PEND : NPC_SEQ;
      end
   end

   fetch_next_pc #(
      .PC_STEP (PC_STEP)
   ) u_next_pc (
      .sel         (npc_sel),
      .pc          (pc),
      .redirect_pc (redirect_pc),
      .pend_pc     (pend_pc),
      .next_pc     (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         pend_pc     <= '0;
         squash      <= 1'b0;
         inst_data_q <= '0;
         inst_pc_q   <= '0;
         fetch_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect_valid) begin
                  pc <= next_pc;
               end else if (enable) begin
                  state <= REQ;
               end
            end

            REQ: begin
               if (bus.mem_ack) begin
                  if (squash || redirect_valid) begin
                     // Wrong-path word: drop it and restart at the new target.
                     pc     <= next_pc;
                     squash <= 1'b0;
                     state  <= enable ? REQ : IDLE;
                  end else begin
                     inst_data_q <= bus.mem_rdata;
                     inst_pc_q   <= pc;
                     pc          <= next_pc;
                     state       <= OUT;
                  end
               end else if (redirect_valid) begin
                  // The request cannot be withdrawn; remember where to go once
                  // it completes. A later redirect overwrites an earlier one.
                  squash  <= 1'b1;
                  pend_pc <= redirect_pc;
               end
            end

            OUT: begin
               if (redirect_valid) begin
                  pc    <= next_pc;
                  state <= enable ? REQ : IDLE;
               end else if (bus.inst_ready) begin
                  fetch_count <= fetch_count + 32'd1;
                  state       <= enable ? REQ : IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode from registered state only; mem_addr reads 0 unless requesting.
   assign bus.mem_req    = (state == REQ);
   assign bus.mem_addr   = (state == REQ) ? pc : '0;
   assign bus.inst_valid = (state == OUT);
   assign bus.inst_data  = inst_data_q;
   assign bus.inst_pc    = inst_pc_q;
   assign busy           = (state != IDLE);

endmodule
